// File: rtl/btb_pkg.sv
// Shared types for the branch target buffer: counter encoding, entry layout
// and the saturating direction-counter update.
package btb_pkg;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_ADDR_W  = 32;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W   = BTB_ADDR_W - BTB_IDX_W - 2;

    typedef enum logic [1:0] {
        BTB_CTR_SNT = 2'b00,
        BTB_CTR_WNT = 2'b01,
        BTB_CTR_WT  = 2'b10,
        BTB_CTR_ST  = 2'b11
    } btb_ctr_t;

    localparam logic [1:0] BTB_CTR_ALLOC = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_ADDR_W-1:0] target;
        btb_ctr_t              ctr;
    } btb_entry_t;

    function automatic btb_ctr_t btb_ctr_next(input btb_ctr_t ctr, input logic taken);
        btb_ctr_t nxt;
        case (ctr)
            BTB_CTR_SNT: nxt = taken ? BTB_CTR_WNT : BTB_CTR_SNT;
            BTB_CTR_WNT: nxt = taken ? BTB_CTR_WT  : BTB_CTR_SNT;
            BTB_CTR_WT:  nxt = taken ? BTB_CTR_ST  : BTB_CTR_WNT;
            BTB_CTR_ST:  nxt = taken ? BTB_CTR_ST  : BTB_CTR_WT;
            default:     nxt = BTB_CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_stat_counter.sv
// Saturating event counter; sticks at all-ones until reset.
module btb_stat_counter #(
    parameter int W = 16
) (
    input  logic         btb_clk,
    input  logic         btb_rst_n,
    input  logic         inc_en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count enabled events, holding once saturated.
    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            count_r <= {W{1'b0}};
        end else if (inc_en && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_target_buffer_table.sv
// Direct-mapped branch target buffer: registered fetch-side prediction,
// execute-side update/allocate, flush, and lookup/hit statistics.
module branch_target_buffer_table
    import btb_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int ADDR_W  = BTB_ADDR_W,
    parameter int STAT_W  = 16
) (
    input  logic              btb_clk,
    input  logic              btb_rst_n,
    input  logic              btb_lookup_valid,
    input  logic [ADDR_W-1:0] btb_lookup_pc,
    output logic              btb_pred_valid,
    output logic              btb_pred_hit,
    output logic              btb_pred_taken,
    output logic [ADDR_W-1:0] btb_pred_target,
    input  logic              btb_update_valid,
    input  logic [ADDR_W-1:0] btb_update_pc,
    input  logic              btb_update_taken,
    input  logic [ADDR_W-1:0] btb_update_target,
    input  logic              btb_flush,
    output logic [STAT_W-1:0] btb_lookup_cnt,
    output logic [STAT_W-1:0] btb_hit_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    btb_entry_t entries_r [ENTRIES];

    logic [IDX_W-1:0]  lk_idx_s;
    logic [BTB_TAG_W-1:0] lk_tag_s;
    btb_entry_t        lk_entry_s;
    logic              lk_hit_s;
    logic              lk_taken_s;
    logic [ADDR_W-1:0] lk_target_s;

    logic [IDX_W-1:0]  up_idx_s;
    logic [BTB_TAG_W-1:0] up_tag_s;
    btb_entry_t        up_entry_s;
    logic              up_hit_s;

    logic              pred_valid_r;
    logic              pred_hit_r;
    logic              pred_taken_r;
    logic [ADDR_W-1:0] pred_target_r;

    // Byte offset within the word never participates in index or tag.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{btb_lookup_pc[1:0], btb_update_pc[1:0]};

    assign lk_idx_s = btb_lookup_pc[IDX_W+1:2];
    assign lk_tag_s = btb_lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx_s = btb_update_pc[IDX_W+1:2];
    assign up_tag_s = btb_update_pc[ADDR_W-1:IDX_W+2];

    // Read the indexed entry from state, so a same-cycle update is not seen.
    always_comb begin
        lk_entry_s = entries_r[lk_idx_s];
        lk_hit_s   = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
        lk_taken_s = lk_hit_s && lk_entry_s.ctr[1];
        if (lk_taken_s) begin
            lk_target_s = lk_entry_s.target;
        end else begin
            lk_target_s = btb_lookup_pc + PC_STEP;
        end
    end

    // Hit detection for the entry being updated.
    always_comb begin
        up_entry_s = entries_r[up_idx_s];
        up_hit_s   = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
    end

    // Register the prediction; idle cycles drive all prediction fields low.
    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            pred_valid_r  <= 1'b0;
            pred_hit_r    <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= {ADDR_W{1'b0}};
        end else if (btb_lookup_valid) begin
            pred_valid_r  <= 1'b1;
            pred_hit_r    <= lk_hit_s;
            pred_taken_r  <= lk_taken_s;
            pred_target_r <= lk_target_s;
        end else begin
            pred_valid_r  <= 1'b0;
            pred_hit_r    <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= {ADDR_W{1'b0}};
        end
    end

    // Table state: flush beats update; taken misses allocate over the old occupant.
    always_ff @(posedge btb_clk or negedge btb_rst_n) begin
        if (!btb_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i].valid  <= 1'b0;
                entries_r[i].tag    <= {BTB_TAG_W{1'b0}};
                entries_r[i].target <= {ADDR_W{1'b0}};
                entries_r[i].ctr    <= BTB_CTR_WNT;
            end
        end else if (btb_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i].valid <= 1'b0;
            end
        end else if (btb_update_valid) begin
            if (up_hit_s) begin
                entries_r[up_idx_s].ctr <= btb_ctr_next(up_entry_s.ctr, btb_update_taken);
                if (btb_update_taken) begin
                    entries_r[up_idx_s].target <= btb_update_target;
                end
            end else if (btb_update_taken) begin
                entries_r[up_idx_s].valid  <= 1'b1;
                entries_r[up_idx_s].tag    <= up_tag_s;
                entries_r[up_idx_s].target <= btb_update_target;
                entries_r[up_idx_s].ctr    <= btb_ctr_t'(BTB_CTR_ALLOC);
            end
        end
    end

    btb_stat_counter #(.W(STAT_W)) u_lookup_cnt (
        .btb_clk   (btb_clk),
        .btb_rst_n (btb_rst_n),
        .inc_en    (btb_lookup_valid),
        .count     (btb_lookup_cnt)
    );

    btb_stat_counter #(.W(STAT_W)) u_hit_cnt (
        .btb_clk   (btb_clk),
        .btb_rst_n (btb_rst_n),
        .inc_en    (btb_lookup_valid & lk_hit_s),
        .count     (btb_hit_cnt)
    );

    assign btb_pred_valid  = pred_valid_r;
    assign btb_pred_hit    = pred_hit_r;
    assign btb_pred_taken  = pred_taken_r;
    assign btb_pred_target = pred_target_r;

endmodule

// File: tb/tb_branch_target_buffer_table.sv
// Directed bench for branch_target_buffer_table: allocation, counter walk,
// aliasing, same-cycle conflicts, stat saturation and asynchronous reset.
module tb_branch_target_buffer_table;

    logic        btb_clk = 1'b0;
    logic        btb_rst_n;
    logic        btb_lookup_valid;
    logic [31:0] btb_lookup_pc;
    logic        btb_pred_valid;
    logic        btb_pred_hit;
    logic        btb_pred_taken;
    logic [31:0] btb_pred_target;
    logic        btb_update_valid;
    logic [31:0] btb_update_pc;
    logic        btb_update_taken;
    logic [31:0] btb_update_target;
    logic        btb_flush;
    logic [15:0] btb_lookup_cnt;
    logic [15:0] btb_hit_cnt;

    int checks = 0;
    int errors = 0;

    branch_target_buffer_table dut (
        .btb_clk           (btb_clk),
        .btb_rst_n         (btb_rst_n),
        .btb_lookup_valid  (btb_lookup_valid),
        .btb_lookup_pc     (btb_lookup_pc),
        .btb_pred_valid    (btb_pred_valid),
        .btb_pred_hit      (btb_pred_hit),
        .btb_pred_taken    (btb_pred_taken),
        .btb_pred_target   (btb_pred_target),
        .btb_update_valid  (btb_update_valid),
        .btb_update_pc     (btb_update_pc),
        .btb_update_taken  (btb_update_taken),
        .btb_update_target (btb_update_target),
        .btb_flush         (btb_flush),
        .btb_lookup_cnt    (btb_lookup_cnt),
        .btb_hit_cnt       (btb_hit_cnt)
    );

    always #5 btb_clk = ~btb_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic hit, input logic taken,
                            input logic [31:0] target);
        chk({tag, ".valid"},  {31'd0, btb_pred_valid}, 32'd1);
        chk({tag, ".hit"},    {31'd0, btb_pred_hit},   {31'd0, hit});
        chk({tag, ".taken"},  {31'd0, btb_pred_taken}, {31'd0, taken});
        chk({tag, ".target"}, btb_pred_target,         target);
    endtask

    // One-cycle lookup; returns at the negedge after the prediction registers.
    task automatic lookup(input logic [31:0] pc);
        @(negedge btb_clk);
        btb_lookup_valid = 1'b1;
        btb_lookup_pc    = pc;
        @(negedge btb_clk);
        btb_lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        @(negedge btb_clk);
        btb_update_valid  = 1'b1;
        btb_update_pc     = pc;
        btb_update_taken  = taken;
        btb_update_target = tgt;
        @(negedge btb_clk);
        btb_update_valid  = 1'b0;
    endtask

    initial begin
        btb_rst_n         = 1'b0;
        btb_lookup_valid  = 1'b0;
        btb_lookup_pc     = 32'd0;
        btb_update_valid  = 1'b0;
        btb_update_pc     = 32'd0;
        btb_update_taken  = 1'b0;
        btb_update_target = 32'd0;
        btb_flush         = 1'b0;
        repeat (3) @(negedge btb_clk);
        chk("rst.pred_valid", {31'd0, btb_pred_valid}, 32'd0);
        chk("rst.pred_target", btb_pred_target, 32'd0);
        chk("rst.lookup_cnt", {16'd0, btb_lookup_cnt}, 32'd0);
        chk("rst.hit_cnt", {16'd0, btb_hit_cnt}, 32'd0);
        btb_rst_n = 1'b1;

        lookup(32'h100);
        chk_pred("miss0", 1'b0, 1'b0, 32'h104);
        chk("miss0.lookup_cnt", {16'd0, btb_lookup_cnt}, 32'd1);
        chk("miss0.hit_cnt", {16'd0, btb_hit_cnt}, 32'd0);

        @(negedge btb_clk);
        chk("idle.pred_valid", {31'd0, btb_pred_valid}, 32'd0);
        chk("idle.pred_target", btb_pred_target, 32'd0);

        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        chk_pred("alloc", 1'b1, 1'b1, 32'h200);
        chk("alloc.hit_cnt", {16'd0, btb_hit_cnt}, 32'd1);

        // 10 -> 01 -> 00
        update(32'h100, 1'b0, 32'h999);
        update(32'h100, 1'b0, 32'h999);
        lookup(32'h100);
        chk_pred("nt2", 1'b1, 1'b0, 32'h104);

        repeat (3) update(32'h100, 1'b0, 32'h999);
        lookup(32'h100);
        chk_pred("nt5", 1'b1, 1'b0, 32'h104);

        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        chk_pred("t1", 1'b1, 1'b0, 32'h104);

        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        chk_pred("t2", 1'b1, 1'b1, 32'h200);

        // 0x140 aliases onto index 0 with a different tag.
        update(32'h140, 1'b1, 32'h300);
        lookup(32'h100);
        chk_pred("alias.old", 1'b0, 1'b0, 32'h104);
        lookup(32'h140);
        chk_pred("alias.new", 1'b1, 1'b1, 32'h300);

        @(negedge btb_clk);
        btb_lookup_valid  = 1'b1;
        btb_lookup_pc     = 32'h180;
        btb_update_valid  = 1'b1;
        btb_update_pc     = 32'h180;
        btb_update_taken  = 1'b1;
        btb_update_target = 32'h400;
        @(negedge btb_clk);
        btb_lookup_valid  = 1'b0;
        btb_update_valid  = 1'b0;
        chk_pred("rdold", 1'b0, 1'b0, 32'h184);
        lookup(32'h180);
        chk_pred("rdold.after", 1'b1, 1'b1, 32'h400);

        // Flush, conflicting update and a lookup all in one cycle.
        @(negedge btb_clk);
        btb_flush         = 1'b1;
        btb_lookup_valid  = 1'b1;
        btb_lookup_pc     = 32'h180;
        btb_update_valid  = 1'b1;
        btb_update_pc     = 32'h1C0;
        btb_update_taken  = 1'b1;
        btb_update_target = 32'h500;
        @(negedge btb_clk);
        btb_flush         = 1'b0;
        btb_lookup_valid  = 1'b0;
        btb_update_valid  = 1'b0;
        chk_pred("flush.prelook", 1'b1, 1'b1, 32'h400);
        lookup(32'h1C0);
        chk_pred("flush.upd", 1'b0, 1'b0, 32'h1C4);
        lookup(32'h180);
        chk_pred("flush.old", 1'b0, 1'b0, 32'h184);
        chk("tally.lookup_cnt", {16'd0, btb_lookup_cnt}, 32'd13);
        chk("tally.hit_cnt", {16'd0, btb_hit_cnt}, 32'd8);

        @(negedge btb_clk);
        btb_lookup_valid = 1'b1;
        btb_lookup_pc    = 32'h100;
        repeat (70000) @(negedge btb_clk);
        btb_lookup_valid = 1'b0;
        chk("sat.lookup_cnt", {16'd0, btb_lookup_cnt}, 32'h0000FFFF);
        lookup(32'h100);
        chk("sat.hold", {16'd0, btb_lookup_cnt}, 32'h0000FFFF);
        chk("sat.hit_cnt", {16'd0, btb_hit_cnt}, 32'd8);

        update(32'h100, 1'b1, 32'h200);
        @(negedge btb_clk);
        btb_lookup_valid = 1'b1;
        btb_lookup_pc    = 32'h100;
        @(posedge btb_clk);
        #2;
        chk("arst.pre_hit", {31'd0, btb_pred_hit}, 32'd1);
        btb_rst_n = 1'b0;
        #1;
        chk("arst.pred_valid", {31'd0, btb_pred_valid}, 32'd0);
        chk("arst.lookup_cnt", {16'd0, btb_lookup_cnt}, 32'd0);
        chk("arst.hit_cnt", {16'd0, btb_hit_cnt}, 32'd0);
        @(negedge btb_clk);
        btb_lookup_valid = 1'b0;
        btb_rst_n        = 1'b1;
        lookup(32'h100);
        chk_pred("arst.miss", 1'b0, 1'b0, 32'h104);
        chk("arst.cnt", {16'd0, btb_lookup_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer_table.md
# branch_target_buffer_table

Storage and lookup side of the branch predictor. Holds a direct-mapped table of branch entries, each with a tag, a target and a 2-bit saturating direction counter. Fetch reads a registered prediction one cycle after presenting a PC. Execute writes resolved outcomes back, which updates the counter and allocates or refreshes entries. Two saturating statistics counters expose lookup and hit totals.

## Interface
- `ENTRIES`, 16: table depth; power of two, ≥ 2. `IDX_W = $clog2(ENTRIES)`.
- `ADDR_W`, 32: PC/target width. Index = `pc[IDX_W+1:2]`, tag = `pc[ADDR_W-1:IDX_W+2]`; `pc[1:0]` is ignored.
- `STAT_W`, 16: statistics counter width.

Ports (name, direction, width, meaning):
- `btb_clk` in 1: clock.
- `btb_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `btb_lookup_valid` in 1: fetch lookup request.
- `btb_lookup_pc` in ADDR_W: fetch PC.
- `btb_pred_valid` out 1: prediction registered this cycle.
- `btb_pred_hit` out 1: entry valid and tag matched.
- `btb_pred_taken` out 1: `hit & ctr[1]`.
- `btb_pred_target` out ADDR_W: stored target if taken, else `lookup_pc + 4`.
- `btb_update_valid` in 1: resolved branch from execute.
- `btb_update_pc` in ADDR_W: resolved branch PC.
- `btb_update_taken` in 1: actual direction.
- `btb_update_target` in ADDR_W: actual target.
- `btb_flush` in 1: invalidate all entries, synchronous.
- `btb_lookup_cnt` out STAT_W: lookups since reset, saturating.
- `btb_hit_cnt` out STAT_W: hits since reset, saturating.

## Operation
- Entry fields: `valid`, `tag`, `target`, `ctr[1:0]`. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset values: all `valid` = 0, `ctr` = 01, `target` = 0. All outputs are 0, including both stat counters.
- Lookup: the indexed entry is read combinationally and all `pred_*` outputs are registered. When `lookup_valid` = 0, `pred_valid` = 0 and the other pred outputs hold 0.
- Update on hit (entry valid and tags equal):
  - Taken: `ctr` saturating +1 (11 stays 11) and `target` is overwritten.
  - Not taken: `ctr` saturating −1 (00 stays 00) and `target` is unchanged.
- Update on miss:
  - Taken: allocate. Set `valid` = 1 and write tag and target; `ctr` = 10. Any previous occupant of that index is evicted.
  - Not taken: no change.
- Flush: clears every `valid` bit at the next edge. Counters and targets are kept. Flush has priority over an update in the same cycle, so the entry ends invalid.
- Stats: `lookup_cnt` increments on each `lookup_valid`. `hit_cnt` increments on each registered hit. Both saturate at all-ones. Only reset clears them; flush does not.

## Timing
- Lookup latency is 1 cycle: a request at edge N produces `pred_*` valid after edge N+1.
- Lookup and update in the same cycle, same index: the lookup returns pre-update contents (read-old). The update is visible to lookups issued from the next cycle on.
- Lookup during a flush cycle returns pre-flush contents. Lookups issued after it miss.
- Updates take effect at the edge they are sampled. One update per cycle; there is no backpressure.
- Asserting `btb_rst_n` low mid-operation clears `pred_*`, the stats and all `valid` bits immediately, without waiting for a clock edge.

## Structure
- Package `btb_pkg` contains:
  - `btb_ctr_t` enum, 2-bit, with the four states above.
  - `btb_entry_t` packed struct, parameterised through localparams.
  - Function `btb_ctr_next(ctr, taken)` implementing the saturating update.
  - Constant `BTB_CTR_ALLOC = 2'b10`.
- Sub-module `btb_stat_counter`: STAT_W saturating counter with increment enable and async active-low reset. It is instantiated twice.

## Test plan
Defaults `ENTRIES` = 16, `ADDR_W` = 32.
- **Reset then miss:** reset, then lookup 0x100 → next cycle `pred_valid` = 1, `hit` = 0, `taken` = 0, `target` = 0x104; `lookup_cnt` = 1, `hit_cnt` = 0.
- **Allocate:** update pc 0x100 taken, target 0x200; then lookup 0x100 → `hit` = 1, `taken` = 1, `target` = 0x200 (ctr 10); `hit_cnt` = 1.
- **Counter walk:**
  - Two not-taken updates at 0x100 → ctr 00; lookup gives `hit` = 1, `taken` = 0, `target` = 0x104.
  - Three more not-taken → still 00.
  - One taken → 01, lookup not taken.
  - Second taken → 10, lookup taken, `target` = 0x200.
- **Alias eviction:** 0x140 shares index 0 with 0x100. Update 0x140 taken, target 0x300 → lookup 0x100 gives `hit` = 0, `target` = 0x104; lookup 0x140 gives `target` = 0x300.
- **Same-cycle conflicts:**
  - Lookup and taken-update of an invalid 0x180 in the same cycle → miss; the following lookup hits.
  - Flush and taken-update of 0x1C0 in the same cycle → the following lookup of 0x1C0 misses.
- **Saturation and async reset:**
  - 70000 consecutive lookups → `lookup_cnt` = 0xFFFF and holds.
  - Drive `btb_rst_n` low between edges → `pred_valid`, `lookup_cnt` and `hit_cnt` read 0 before the next edge, and lookup 0x100 misses afterwards.
